alu_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_pipe_core.sv | 65 ++++++
 rtl/alu_pipe.sv | 112 +++++++++++
 tb/tb_alu_pipe.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encoding and shared constants for alu_pipe
package alu_pkg;

    localparam int OPW_DEF = 3;

    localparam int unsigned OP_ADD   = 0;
    localparam int unsigned OP_INC   = 1;
    localparam int unsigned OP_NEG   = 2;
    localparam int unsigned OP_SUB   = 3;
    localparam int unsigned OP_PASSB = 4;

    // Everything above PASSB is reserved and reported through out_err.
    function automatic logic is_legal_op(input int unsigned op);
        return op <= OP_PASSB;
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// rtl/alu_pipe_core.sv - combinational operand select and adder shared by every alu_pipe opcode
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = OPW_DEF
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             cin_msb
);

    localparam logic [OPW-1:0] C_ADD   = OPW'(OP_ADD);
    localparam logic [OPW-1:0] C_INC   = OPW'(OP_INC);
    localparam logic [OPW-1:0] C_NEG   = OPW'(OP_NEG);
    localparam logic [OPW-1:0] C_SUB   = OPW'(OP_SUB);
    localparam logic [OPW-1:0] C_PASSB = OPW'(OP_PASSB);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH:0]   total;

    // Every opcode is folded onto a single x + y + cin adder.
    always_comb begin
        x   = '0;
        y   = '0;
        cin = 1'b0;
        case (op)
            C_ADD: begin
                x = a;
                y = b;
            end
            C_INC: begin
                x   = a;
                cin = 1'b1;
            end
            C_NEG: begin
                x   = ~a;
                cin = 1'b1;
            end
            C_SUB: begin
                x   = a;
                y   = ~b;
                cin = 1'b1;
            end
            C_PASSB: begin
                y = b;
            end
            default: begin
                x = '0;
            end
        endcase
    end

    assign total   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    assign sum     = total[WIDTH-1:0];
    assign cout    = total[WIDTH];
    // Carry into the MSB is recovered from the MSB sum bit and its two operands.
    assign cin_msb = x[WIDTH-1] ^ y[WIDTH-1] ^ sum[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU with Z/N/err flags; V/C flags under ALU_PIPE_OVF_EN
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = OPW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v,
    output logic             out_c,
    output logic             out_err
);

    logic             s1_valid;
    logic [OPW-1:0]   s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_load;
    logic             s1_load;
    logic             legal;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             cin_msb;
    logic [WIDTH-1:0] res_d;

    // No skid buffer: in_ready is combinational from out_ready through the S2 advance.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= in_op;
                s1_a  <= in_a;
                s1_b  <= in_b;
            end
        end
    end

    alu_pipe_core #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_core (
        .op      (s1_op),
        .a       (s1_a),
        .b       (s1_b),
        .sum     (sum),
        .cout    (cout),
        .cin_msb (cin_msb)
    );

    assign legal = is_legal_op(32'(s1_op));
    assign res_d = legal ? sum : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_z     <= 1'b1;
            out_n     <= 1'b0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_res <= res_d;
                out_z   <= (res_d == '0);
                out_n   <= res_d[WIDTH-1];
                out_err <= !legal;
            end
        end
    end

`ifdef ALU_PIPE_OVF_EN
    logic arith;

    // PASSB and reserved codes never report carry or overflow.
    assign arith = legal && (s1_op != OPW'(OP_PASSB));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_v <= 1'b0;
            out_c <= 1'b0;
        end else if (s2_load && s1_valid) begin
            out_v <= arith && (cin_msb ^ cout);
            out_c <= arith && cout;
        end
    end
`else
    logic unused_carry;

    assign unused_carry = cout ^ cin_msb;
    assign out_v        = 1'b0;
    assign out_c        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed bench for alu_pipe at WIDTH 32 and 8
module tb_alu_pipe;
    import alu_pkg::*;

`ifdef ALU_PIPE_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        v;
        logic        c;
        logic        err;
    } beat_t;

    typedef struct {
        bit    valid;
        bit    in_ready;
        beat_t b;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv32, ir32, ov32, or32, z32, n32, v32, c32, e32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, res32;

    logic        iv8, ir8, ov8, or8, z8, n8, v8, c8, e8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, res8;

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];

    alu_pipe #(.WIDTH(32), .OPW(3)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_op(op32),
        .in_a(a32), .in_b(b32), .out_valid(ov32), .out_ready(or32), .out_res(res32),
        .out_z(z32), .out_n(n32), .out_v(v32), .out_c(c32), .out_err(e32)
    );

    alu_pipe #(.WIDTH(8), .OPW(3)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_op(op8),
        .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(or8), .out_res(res8),
        .out_z(z8), .out_n(n8), .out_v(v8), .out_c(c8), .out_err(e8)
    );

    // Reference: exact integer arithmetic, then reduce mod 2^w and judge signed range.
    function automatic beat_t model(input int w, input logic [2:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
        beat_t r;
        longint unsigned m, ua, ub, full;
        longint sa, sb, sres, half;
        bit arith;
        m    = 64'd1 << w;
        half = longint'(m / 2);
        ua   = {32'd0, a} % m;
        ub   = {32'd0, b} % m;
        sa   = (longint'(ua) >= half) ? longint'(ua) - longint'(m) : longint'(ua);
        sb   = (longint'(ub) >= half) ? longint'(ub) - longint'(m) : longint'(ub);
        arith = 1'b1;
        r.err = 1'b0;
        full  = 0;
        sres  = 0;
        case (int'(op))
            OP_ADD:   begin full = ua + ub;              sres = sa + sb; end
            OP_INC:   begin full = ua + 1;               sres = sa + 1;  end
            OP_NEG:   begin full = (m - 1 - ua) + 1;     sres = -sa;     end
            OP_SUB:   begin full = ua + (m - 1 - ub) + 1; sres = sa - sb; end
            OP_PASSB: begin full = ub; arith = 1'b0; end
            default:  begin full = 0; arith = 1'b0; r.err = 1'b1; end
        endcase
        r.res = 32'(full % m);
        r.z   = (r.res == 32'd0);
        r.n   = r.res[w-1];
        r.c   = OVF_EN && arith && (full >= m);
        r.v   = OVF_EN && arith && (sres < -half || sres >= half);
        return r;
    endfunction

    task automatic cycle32(input bit iv, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit ordy,
                           output bit acc, output bit pop, output obs_t o);
        iv32 = iv; op32 = op; a32 = a; b32 = b; or32 = ordy;
        #1;
        o.valid    = ov32;
        o.in_ready = ir32;
        o.b        = {res32, z32, n32, v32, c32, e32};
        acc        = iv && ir32;
        pop        = ov32 && ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle8(input bit iv, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input bit ordy,
                          output bit acc, output bit pop, output obs_t o);
        iv8 = iv; op8 = op; a8 = a; b8 = b; or8 = ordy;
        #1;
        o.valid    = ov8;
        o.in_ready = ir8;
        o.b        = {24'd0, res8, z8, n8, v8, c8, e8};
        acc        = iv && ir8;
        pop        = ov8 && ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({ov32, ir32} !== 2'b01) begin
            errors++; $display("FAIL reset_hs32: valid/ready=%b want 01", {ov32, ir32});
        end
        checks++;
        if ({res32, z32, n32, v32, c32, e32} !== {32'd0, 5'b10000}) begin
            errors++; $display("FAIL reset_out32: res=%h zncve=%b want 0/10000", res32, {z32, n32, v32, c32, e32});
        end
        checks++;
        if ({ov8, ir8, res8, z8, n8, v8, c8, e8} !== {2'b01, 8'd0, 5'b10000}) begin
            errors++; $display("FAIL reset_8: v/r=%b res=%h zncve=%b", {ov8, ir8}, res8, {z8, n8, v8, c8, e8});
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops[3] = '{3'(OP_ADD), 3'(OP_SUB), 3'(OP_INC)};
        logic [31:0] as[3]  = '{32'd5, 32'd3, 32'hFFFF_FFFF};
        logic [31:0] bs[3]  = '{32'd7, 32'd5, 32'd0};
        logic [33:0] kat[3] = '{{32'd12, 2'b00}, {32'hFFFF_FFFE, 2'b01}, {32'd0, 2'b10}};
        int k = 0;
        bit acc, pop;
        obs_t o;
        beat_t e;
        for (int i = 0; i < 7; i++) begin
            if (i < 3) cycle32(1'b1, ops[i], as[i], bs[i], 1'b1, acc, pop, o);
            else       cycle32(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, acc, pop, o);
            checks++;
            if (o.valid !== (i >= 2 && i <= 4)) begin
                errors++; $display("FAIL b2b_latency: cycle %0d out_valid=%0d", i, o.valid);
            end
            if (pop) begin
                checks++;
                if (k >= 3 || {o.b.res, o.b.z, o.b.n} !== kat[k]) begin
                    errors++; $display("FAIL b2b_kat: beat %0d res=%h z%0d n%0d", k, o.b.res, o.b.z, o.b.n);
                end
                k++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: res=%h", o.b.res);
                end else begin
                    e = exp_q.pop_front();
                    if (o.b !== e) begin
                        errors++; $display("FAIL b2b_model: got %h/%b want %h/%b", o.b.res, o.b[4:0], e.res, e[4:0]);
                    end
                end
            end
            if (acc) exp_q.push_back(model(32, ops[i], as[i], bs[i]));
        end
        checks++;
        if (k !== 3) begin
            errors++; $display("FAIL b2b_count: got %0d beats want 3", k);
        end
    endtask

    task automatic test_ovf();
        logic [2:0]  ops[2] = '{3'(OP_NEG), 3'(OP_ADD)};
        logic [31:0] as[2]  = '{32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs[2]  = '{32'd0, 32'd1};
        beat_t kat[2];
        int k = 0;
        bit acc, pop;
        obs_t o;
        kat[0] = {32'h8000_0000, 1'b0, 1'b1, OVF_EN, 1'b0, 1'b0};
        kat[1] = {32'd0, 1'b1, 1'b0, 1'b0, OVF_EN, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if (i < 2) cycle32(1'b1, ops[i], as[i], bs[i], 1'b1, acc, pop, o);
            else       cycle32(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, acc, pop, o);
            if (pop) begin
                checks++;
                if (k >= 2 || o.b !== kat[k]) begin
                    errors++; $display("FAIL ovf_kat: beat %0d got %h/%b", k, o.b.res, o.b[4:0]);
                end
                k++;
            end
        end
        checks++;
        if (k !== 2) begin
            errors++; $display("FAIL ovf_count: got %0d beats want 2", k);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0]  ops[3];
        logic [31:0] as[3], bs[3];
        int idx = 0, npop = 0;
        bit acc, pop;
        obs_t o;
        beat_t e, held;
        held = '0;
        for (int j = 0; j < 3; j++) begin
            ops[j] = 3'($urandom_range(0, 4));
            as[j]  = $urandom;
            bs[j]  = $urandom;
        end
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (idx < 3) cycle32(1'b1, ops[idx], as[idx], bs[idx], cyc >= 4, acc, pop, o);
            else         cycle32(1'b0, 3'd0, 32'd0, 32'd0, cyc >= 4, acc, pop, o);
            if (cyc == 2 || cyc == 3) begin
                checks++;
                if (o.in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready: cycle %0d in_ready=%0d want 0", cyc, o.in_ready);
                end
            end
            if (cyc == 2) held = o.b;
            if (cyc == 3 || cyc == 4) begin
                checks++;
                if (o.b !== held || o.valid !== 1'b1) begin
                    errors++; $display("FAIL bp_hold: cycle %0d res=%h want %h", cyc, o.b.res, held.res);
                end
            end
            if (pop) begin
                npop++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: res=%h", o.b.res);
                end else begin
                    e = exp_q.pop_front();
                    if (o.b !== e) begin
                        errors++; $display("FAIL bp_model: got %h/%b want %h/%b", o.b.res, o.b[4:0], e.res, e[4:0]);
                    end
                end
            end
            if (acc) begin
                exp_q.push_back(model(32, ops[idx], as[idx], bs[idx]));
                idx++;
            end
        end
        checks++;
        if (idx !== 3 || npop !== 3) begin
            errors++; $display("FAIL bp_count: accepted %0d popped %0d want 3/3", idx, npop);
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  ops[2] = '{3'd6, 3'(OP_ADD)};
        beat_t kat[2];
        int k = 0;
        bit acc, pop;
        obs_t o;
        kat[0] = {32'd0, 5'b10001};
        kat[1] = {32'd18, 5'b00000};
        for (int i = 0; i < 6; i++) begin
            if (i < 2) cycle32(1'b1, ops[i], 32'd9, 32'd9, 1'b1, acc, pop, o);
            else       cycle32(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, acc, pop, o);
            if (pop) begin
                checks++;
                if (k >= 2 || o.b !== kat[k]) begin
                    errors++; $display("FAIL illegal_kat: beat %0d got %h/%b", k, o.b.res, o.b[4:0]);
                end
                k++;
            end
        end
        checks++;
        if (k !== 2) begin
            errors++; $display("FAIL illegal_count: got %0d beats want 2", k);
        end
    endtask

    function automatic logic [31:0] pick32();
        logic [31:0] corners[5] = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1};
        return ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
    endfunction

    task automatic test_random();
        bit acc, pop, iv, ordy, stalled;
        logic [2:0]  op;
        logic [31:0] a, b;
        obs_t o;
        beat_t e, prev;
        stalled = 1'b0;
        prev    = '0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            iv   = (cyc < 400) && ($urandom_range(0, 3) != 0);
            ordy = (cyc >= 400) || ($urandom_range(0, 9) < 7);
            op   = 3'($urandom_range(0, 7));
            a    = pick32();
            b    = pick32();
            cycle32(iv, op, a, b, ordy, acc, pop, o);
            if (stalled) begin
                checks++;
                if (o.valid !== 1'b1 || o.b !== prev) begin
                    errors++; $display("FAIL rnd_hold: cycle %0d res=%h want %h", cyc, o.b.res, prev.res);
                end
            end
            stalled = o.valid && !ordy;
            prev    = o.b;
            if (pop) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra: res=%h", o.b.res);
                end else begin
                    e = exp_q.pop_front();
                    if (o.b !== e) begin
                        errors++; $display("FAIL rnd_model: got %h/%b want %h/%b", o.b.res, o.b[4:0], e.res, e[4:0]);
                    end
                end
            end
            if (acc) exp_q.push_back(model(32, op, a, b));
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rnd_drain: %0d beats never emitted", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_midstream();
        bit acc0, acc1, pop;
        obs_t o;
        cycle32(1'b1, 3'(OP_ADD), 32'd1, 32'd2, 1'b0, acc0, pop, o);
        cycle32(1'b1, 3'(OP_SUB), 32'd4, 32'd1, 1'b0, acc1, pop, o);
        checks++;
        if ({acc0, acc1} !== 2'b11) begin
            errors++; $display("FAIL rstmid_fill: accepts=%b want 11", {acc0, acc1});
        end
        rst = 1'b1; iv32 = 1'b1; op32 = 3'(OP_INC); or32 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({ov32, ir32, res32, z32, n32, v32, c32, e32} !== {2'b01, 32'd0, 5'b10000}) begin
            errors++; $display("FAIL rstmid_state: v/r=%b res=%h zncve=%b", {ov32, ir32}, res32, {z32, n32, v32, c32, e32});
        end
        for (int i = 0; i < 6; i++) begin
            cycle32(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, acc0, pop, o);
            checks++;
            if (o.valid !== 1'b0) begin
                errors++; $display("FAIL rstmid_stale: cycle %0d res=%h emitted", i, o.b.res);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_width8();
        logic [2:0] ops[2] = '{3'(OP_SUB), 3'(OP_PASSB)};
        logic [7:0] as[2]  = '{8'h00, 8'h33};
        logic [7:0] bs[2]  = '{8'h01, 8'h5A};
        beat_t kat[2];
        int k = 0;
        bit acc, pop, iv;
        logic [2:0] op;
        logic [7:0] a, b;
        obs_t o;
        beat_t e;
        kat[0] = {32'h0000_00FF, 5'b01000};
        kat[1] = {32'h0000_005A, 5'b00000};
        for (int i = 0; i < 6; i++) begin
            if (i < 2) cycle8(1'b1, ops[i], as[i], bs[i], 1'b1, acc, pop, o);
            else       cycle8(1'b0, 3'd0, 8'd0, 8'd0, 1'b1, acc, pop, o);
            if (pop) begin
                checks++;
                if (k >= 2 || o.b !== kat[k]) begin
                    errors++; $display("FAIL w8_kat: beat %0d got %h/%b", k, o.b.res, o.b[4:0]);
                end
                k++;
            end
        end
        checks++;
        if (k !== 2) begin
            errors++; $display("FAIL w8_count: got %0d beats want 2", k);
        end
        for (int cyc = 0; cyc < 160; cyc++) begin
            iv = (cyc < 150) && ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            cycle8(iv, op, a, b, (cyc >= 150) || ($urandom_range(0, 3) != 0), acc, pop, o);
            if (pop) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL w8_extra: res=%h", o.b.res);
                end else begin
                    e = exp_q.pop_front();
                    if (o.b !== e) begin
                        errors++; $display("FAIL w8_model: got %h/%b want %h/%b", o.b.res, o.b[4:0], e.res, e[4:0]);
                    end
                end
            end
            if (acc) exp_q.push_back(model(8, op, {24'd0, a}, {24'd0, b}));
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL w8_drain: %0d beats never emitted", exp_q.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        iv32 = 1'b0; op32 = 3'd0; a32 = 32'd0; b32 = 32'd0; or32 = 1'b1;
        iv8  = 1'b0; op8  = 3'd0; a8  = 8'd0;  b8  = 8'd0;  or8  = 1'b1;
        test_reset();
        test_back_to_back();
        test_ovf();
        test_backpressure();
        test_illegal();
        test_random();
        test_reset_midstream();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
